vga_scanout: RTL

- Display-side consumer of the CPU framebuffer's read port.
- Generates 640x480@60 Hz VGA timing on vga_clk and issues framebuffer read addresses for a centred 200x200 image window (40000 words).
- Accounts for the one-cycle synchronous RAM read latency and drives RGB, sync and blank signals aligned to the returned pixel data.
- Replaces the free-running address counter on the framebuffer's second port.

---
 rtl/vga_pkg.sv | 37 +++
 rtl/vga_scanout_if.sv | 13 +
 rtl/vga_timing_gen.sv | 68 ++++++
 rtl/vga_scanout.sv | 123 ++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared timing constants and the pipeline payload type for the VGA scanout path.
// The constants are the 640x480@60 defaults; the modules take them as parameter defaults.
package vga_pkg;

   localparam int H_ACTIVE = 640;
   localparam int H_FP     = 16;
   localparam int H_SYNC   = 96;
   localparam int H_BP     = 48;
   localparam int V_ACTIVE = 480;
   localparam int V_FP     = 10;
   localparam int V_SYNC   = 2;
   localparam int V_BP     = 33;
   localparam int IMG_W    = 200;
   localparam int IMG_H    = 200;
   localparam int IMG_X0   = 220;
   localparam int IMG_Y0   = 140;
   localparam int ADDR_W   = 32;

   localparam int H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int H_SYNC_START = H_ACTIVE + H_FP;
   localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
   localparam int V_SYNC_START = V_ACTIVE + V_FP;
   localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

   localparam int CNT_W = 10;

   typedef struct packed {
      logic hsync_n;
      logic vsync_n;
      logic blank_n;
      logic in_win;
   } vga_timing_t;

   localparam vga_timing_t TIMING_IDLE = '{hsync_n: 1'b1, vsync_n: 1'b1, blank_n: 1'b0, in_win: 1'b0};

endpackage

// File: rtl/vga_scanout_if.sv
// Framebuffer read port as seen from the display side: address out, RAM q back.
interface vga_scanout_if #(
   parameter int ADDR_W = vga_pkg::ADDR_W
);

   logic [ADDR_W-1:0] fb_addr;
   logic              fb_rd_en;
   logic [31:0]       fb_data;

   modport master (output fb_addr, output fb_rd_en, input fb_data);
   modport slave  (input fb_addr, input fb_rd_en, output fb_data);

endinterface

// File: rtl/vga_timing_gen.sv
// Horizontal/vertical raster counters and the stage-0 decode of sync, blank and image window.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
   parameter int H_FP     = vga_pkg::H_FP,
   parameter int H_SYNC   = vga_pkg::H_SYNC,
   parameter int H_BP     = vga_pkg::H_BP,
   parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
   parameter int V_FP     = vga_pkg::V_FP,
   parameter int V_SYNC   = vga_pkg::V_SYNC,
   parameter int V_BP     = vga_pkg::V_BP,
   parameter int IMG_W    = vga_pkg::IMG_W,
   parameter int IMG_H    = vga_pkg::IMG_H,
   parameter int IMG_X0   = vga_pkg::IMG_X0,
   parameter int IMG_Y0   = vga_pkg::IMG_Y0
) (
   input  logic             vga_clk,
   input  logic             reset,
   input  logic             enable,
   output logic [CNT_W-1:0] h_cnt,
   output logic [CNT_W-1:0] v_cnt,
   output vga_timing_t      timing,
   output logic             origin,
   output logic             line_end,
   output logic             frame_end
);

   localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
   localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
   localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
   localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] X_START  = CNT_W'(IMG_X0);
   localparam logic [CNT_W-1:0] X_END    = CNT_W'(IMG_X0 + IMG_W);
   localparam logic [CNT_W-1:0] X_LAST   = CNT_W'(IMG_X0 + IMG_W - 1);
   localparam logic [CNT_W-1:0] Y_START  = CNT_W'(IMG_Y0);
   localparam logic [CNT_W-1:0] Y_END    = CNT_W'(IMG_Y0 + IMG_H);

   // Disabled or in reset the raster parks at the origin, so scanning resumes from (0,0).
   always_ff @(posedge vga_clk) begin
      if (reset || !enable) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (h_cnt == H_LAST) begin
         h_cnt <= '0;
         v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
         h_cnt <= h_cnt + 1'b1;
      end
   end

   always_comb begin
      timing         = TIMING_IDLE;
      timing.hsync_n = !((h_cnt >= HS_START) && (h_cnt < HS_END));
      timing.vsync_n = !((v_cnt >= VS_START) && (v_cnt < VS_END));
      timing.blank_n = (h_cnt < H_VIS) && (v_cnt < V_VIS);
      timing.in_win  = (h_cnt >= X_START) && (h_cnt < X_END) &&
                       (v_cnt >= Y_START) && (v_cnt < Y_END);
      origin         = (h_cnt == '0) && (v_cnt == '0);
      line_end       = timing.in_win && (h_cnt == X_LAST);
      frame_end      = (h_cnt == H_LAST) && (v_cnt == V_LAST);
   end

endmodule

// File: rtl/vga_scanout.sv
// VGA scanout: drives framebuffer read addresses for a centred image window and
// aligns sync/blank/RGB with the data returned one cycle later by the RAM.
module vga_scanout
   import vga_pkg::*;
#(
   parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
   parameter int H_FP     = vga_pkg::H_FP,
   parameter int H_SYNC   = vga_pkg::H_SYNC,
   parameter int H_BP     = vga_pkg::H_BP,
   parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
   parameter int V_FP     = vga_pkg::V_FP,
   parameter int V_SYNC   = vga_pkg::V_SYNC,
   parameter int V_BP     = vga_pkg::V_BP,
   parameter int IMG_W    = vga_pkg::IMG_W,
   parameter int IMG_H    = vga_pkg::IMG_H,
   parameter int IMG_X0   = vga_pkg::IMG_X0,
   parameter int IMG_Y0   = vga_pkg::IMG_Y0,
   parameter int ADDR_W   = vga_pkg::ADDR_W
) (
   input  logic         vga_clk,
   input  logic         reset,
   input  logic         enable,
   vga_scanout_if.master fb,
   output logic [7:0]   red,
   output logic [7:0]   green,
   output logic [7:0]   blue,
   output logic         hsync_n,
   output logic         vsync_n,
   output logic         blank_n,
   output logic         frame_start
);

   logic [CNT_W-1:0]  h_cnt;
   logic [CNT_W-1:0]  v_cnt;
   vga_timing_t       timing_s0;
   vga_timing_t       timing_s1;
   vga_timing_t       timing_s2;
   logic              origin_s0;
   logic              origin_s1;
   logic              origin_s2;
   logic              line_end;
   logic              frame_end;
   logic [CNT_W-1:0]  col;
   logic [ADDR_W-1:0] row_base;
   logic [ADDR_W-1:0] addr_q;
   logic              unused_data;

   vga_timing_gen #(
      .H_ACTIVE (H_ACTIVE),
      .H_FP     (H_FP),
      .H_SYNC   (H_SYNC),
      .H_BP     (H_BP),
      .V_ACTIVE (V_ACTIVE),
      .V_FP     (V_FP),
      .V_SYNC   (V_SYNC),
      .V_BP     (V_BP),
      .IMG_W    (IMG_W),
      .IMG_H    (IMG_H),
      .IMG_X0   (IMG_X0),
      .IMG_Y0   (IMG_Y0)
   ) u_timing (
      .vga_clk   (vga_clk),
      .reset     (reset),
      .enable    (enable),
      .h_cnt     (h_cnt),
      .v_cnt     (v_cnt),
      .timing    (timing_s0),
      .origin    (origin_s0),
      .line_end  (line_end),
      .frame_end (frame_end)
   );

   assign col = h_cnt - CNT_W'(IMG_X0);

   // row_base steps by one image line after the last window pixel, so the
   // address is a simple add with no multiplier; it restarts at each frame wrap.
   always_ff @(posedge vga_clk) begin
      if (reset || !enable) begin
         timing_s1 <= TIMING_IDLE;
         timing_s2 <= TIMING_IDLE;
         origin_s1 <= 1'b0;
         origin_s2 <= 1'b0;
         row_base  <= '0;
         addr_q    <= '0;
      end else begin
         timing_s1 <= timing_s0;
         timing_s2 <= timing_s1;
         origin_s1 <= origin_s0;
         origin_s2 <= origin_s1;
         if (timing_s0.in_win) begin
            addr_q <= row_base + ADDR_W'(col);
         end
         if (frame_end) begin
            row_base <= '0;
         end else if (line_end) begin
            row_base <= row_base + ADDR_W'(IMG_W);
         end
      end
   end

   assign fb.fb_addr  = addr_q;
   assign fb.fb_rd_en = timing_s1.in_win;

   assign hsync_n     = timing_s2.hsync_n;
   assign vsync_n     = timing_s2.vsync_n;
   assign blank_n     = timing_s2.blank_n;
   assign frame_start = origin_s2;

   // RAM q arrives in the stage-2 cycle, so the colour mux stays combinational.
   always_comb begin
      red   = 8'h00;
      green = 8'h00;
      blue  = 8'h00;
      if (timing_s2.in_win) begin
         red   = fb.fb_data[23:16];
         green = fb.fb_data[15:8];
         blue  = fb.fb_data[7:0];
      end
   end

   assign unused_data = &{1'b0, fb.fb_data[31:24]};

endmodule
